// File: rtl/ise_sorter_param.sv
// Image sorting engine: classifies streamed images by dominant colour channel,
// sorts the records by colour and channel intensity, then emits them one per cycle.
module ise_sorter_param #(
  parameter int IMAGE_NUM = 32,
  parameter int PIXELS    = 16384,
  parameter int CH_W      = 8,
  parameter int IDX_W     = $clog2(IMAGE_NUM),
  parameter int SUM_W     = CH_W + $clog2(PIXELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [IDX_W-1:0]    image_in_index,
  input  logic [3*CH_W-1:0]   pixel_in,
  input  logic                sort_desc,
  output logic                busy,
  output logic                out_valid,
  output logic [1:0]          color_index,
  output logic [IDX_W-1:0]    image_out_index
);
  localparam int PIX_W = $clog2(PIXELS);
  localparam int CNT_W = PIX_W + 1;

  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;
  typedef struct packed {
    logic [1:0]       col;
    logic [SUM_W-1:0] key;
    logic [IDX_W-1:0] idx;
  } rec_t;

  state_t                  state, state_n;
  logic [PIX_W-1:0]        pix_cnt;
  logic [IDX_W-1:0]        img_cnt, pass_cnt;
  logic [IDX_W:0]          out_cnt;
  logic [CNT_W-1:0]        cnt_r, cnt_g, cnt_b, nr, ng, nb;
  logic [SUM_W-1:0]        sum_r, sum_g, sum_b, sr, sg, sb;
  logic [CH_W-1:0]         pr, pg, pb;
  logic                    dom_r, dom_g, dom_b, accept, last_pix, last_img, last_pass, desc_q;
  rec_t                    rec_new;
  rec_t [IMAGE_NUM-1:0]    slots, sorted;

  // True when record a must be placed after record b.
  function automatic logic after(input rec_t a, input rec_t b, input logic desc);
    if (a.col != b.col) return a.col > b.col;
    if (a.key != b.key) return desc ? (a.key < b.key) : (a.key > b.key);
    return a.idx > b.idx;
  endfunction

  assign {pr, pg, pb} = pixel_in;
  assign dom_r    = (pr >= pg) && (pr >= pb);
  assign dom_g    = !dom_r && (pg >= pb);
  assign dom_b    = !dom_r && !dom_g;
  assign nr       = cnt_r + CNT_W'(dom_r);
  assign ng       = cnt_g + CNT_W'(dom_g);
  assign nb       = cnt_b + CNT_W'(dom_b);
  assign sr       = sum_r + SUM_W'(pr);
  assign sg       = sum_g + SUM_W'(pg);
  assign sb       = sum_b + SUM_W'(pb);
  assign accept   = in_valid && !busy;
  assign last_pix = (pix_cnt == PIX_W'(PIXELS - 1));
  assign last_img = (img_cnt == IDX_W'(IMAGE_NUM - 1));
  assign last_pass = (pass_cnt == IDX_W'(IMAGE_NUM - 1));

  // Record for the image whose final beat is on the bus (counts include this beat).
  always_comb begin
    rec_new     = '0;
    rec_new.idx = image_in_index;
    if (nr >= ng && nr >= nb) begin
      rec_new.col = 2'd0;
      rec_new.key = sr;
    end else if (ng >= nb) begin
      rec_new.col = 2'd1;
      rec_new.key = sg;
    end else begin
      rec_new.col = 2'd2;
      rec_new.key = sb;
    end
  end

  // One odd-even transposition pass; even passes pair (0,1),(2,3)..., odd passes (1,2),...
  always_comb begin
    sorted = slots;
    for (int i = 0; i + 1 < IMAGE_NUM; i++) begin
      if (((i % 2) == 1) == pass_cnt[0] && after(slots[i], slots[i+1], desc_q)) begin
        sorted[i]   = slots[i+1];
        sorted[i+1] = slots[i];
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      LOAD:    if (accept && last_pix && last_img) state_n = SORT;
      SORT:    if (last_pass) state_n = OUT;
      OUT:     if (out_cnt == (IDX_W+1)'(IMAGE_NUM)) state_n = LOAD;
      default: state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= LOAD;
      busy            <= 1'b0;
      out_valid       <= 1'b0;
      color_index     <= '0;
      image_out_index <= '0;
      pix_cnt         <= '0;
      img_cnt         <= '0;
      pass_cnt        <= '0;
      out_cnt         <= '0;
      cnt_r <= '0; cnt_g <= '0; cnt_b <= '0;
      sum_r <= '0; sum_g <= '0; sum_b <= '0;
      desc_q          <= 1'b0;
      slots           <= '0;
    end else begin
      state           <= state_n;
      busy            <= (state_n != LOAD);
      out_valid       <= 1'b0;
      color_index     <= '0;
      image_out_index <= '0;
      case (state)
        LOAD: if (accept) begin
          if (last_pix) begin
            slots[image_in_index] <= rec_new;
            pix_cnt  <= '0;
            cnt_r <= '0; cnt_g <= '0; cnt_b <= '0;
            sum_r <= '0; sum_g <= '0; sum_b <= '0;
            img_cnt  <= last_img ? '0 : img_cnt + 1'b1;
            pass_cnt <= '0;
            if (last_img) desc_q <= sort_desc;
          end else begin
            pix_cnt <= pix_cnt + 1'b1;
            cnt_r <= nr; cnt_g <= ng; cnt_b <= nb;
            sum_r <= sr; sum_g <= sg; sum_b <= sb;
          end
        end
        SORT: begin
          slots    <= sorted;
          pass_cnt <= pass_cnt + 1'b1;
          // The final pass feeds slot 0 straight to the output register.
          if (last_pass) begin
            out_valid       <= 1'b1;
            color_index     <= sorted[0].col;
            image_out_index <= sorted[0].idx;
            out_cnt         <= (IDX_W+1)'(1);
          end
        end
        OUT: if (out_cnt != (IDX_W+1)'(IMAGE_NUM)) begin
          out_valid       <= 1'b1;
          color_index     <= slots[out_cnt[IDX_W-1:0]].col;
          image_out_index <= slots[out_cnt[IDX_W-1:0]].idx;
          out_cnt         <= out_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ise_sorter_param.sv
// Directed bench for ise_sorter_param (4 images of 4 pixels); a negedge monitor
// compares emitted records against a queue of expected {colour, index} pairs.
module tb_ise_sorter_param;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, sort_desc = 1'b0;
  logic [1:0]  image_in_index = '0;
  logic [23:0] pixel_in = '0;
  logic        busy, out_valid;
  logic [1:0]  color_index, image_out_index;

  int   checks = 0, errors = 0;
  bit   gaps = 0, mon_en = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_e;

  ise_sorter_param #(.IMAGE_NUM(4), .PIXELS(4), .CH_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .image_in_index(image_in_index),
    .pixel_in(pixel_in), .sort_desc(sort_desc), .busy(busy), .out_valid(out_valid),
    .color_index(color_index), .image_out_index(image_out_index));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("stale_record", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("out_color", 32'(color_index), 32'(mon_e[3:2]));
        chk("out_index", 32'(image_out_index), 32'(mon_e[1:0]));
      end
    end else begin
      chk("idle_color", 32'(color_index), 0);
      chk("idle_index", 32'(image_out_index), 0);
    end
  end

  task automatic push(input logic [1:0] c, input logic [1:0] i);
    exp_q.push_back({c, i});
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [1:0] idx, input logic [23:0] pix);
    int n = 0;
    bit acc;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      in_valid = 1'b0; pixel_in = 24'($urandom); image_in_index = 2'($urandom); tick();
    end
    image_in_index = idx; pixel_in = pix; in_valid = 1'b1;
    do begin acc = !busy; tick(); n++; end while (!acc && n < 100);
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_image(input logic [1:0] idx, input logic [23:0] pix);
    repeat (4) send_beat(idx, pix);
  endtask

  // Images of the basic run; rec: img0 R/800, img1 G/200, img2 B/360, img3 R/400.
  task automatic send_basic(input logic [1:0] o0, o1, o2, o3);
    logic [1:0]  ord[4];
    logic [23:0] img[4];
    img = '{24'hC80A0A, 24'h0A320A, 24'h0A0A5A, 24'h640A0A};
    ord = '{o0, o1, o2, o3};
    foreach (ord[k]) send_image(ord[k], img[ord[k]]);
  endtask

  task automatic push_asc();
    push(0, 3); push(0, 0); push(1, 1); push(2, 2);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_color"}, 32'(color_index), 0);
    chk({tag, "_index"}, 32'(image_out_index), 0);
  endtask

  task automatic do_reset(input int cycles, input string tag);
    reset = 1'b1;
    repeat (cycles) tick();
    check_zero(tag);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin tick(); n++; end
    chk("drain", exp_q.size(), 0);
    repeat (2) tick();
  endtask

  initial begin
    do_reset(3, "rst_init");
    mon_en = 1;

    // Partial frame, then reset mid-LOAD.
    send_image(0, 24'hC80A0A);
    send_beat(1, 24'h0A320A); send_beat(1, 24'h0A320A);
    do_reset(2, "rst_load");

    // Basic ascending with cycle-exact busy / out_valid timing.
    sort_desc = 1'b0;
    push_asc();
    send_basic(0, 1, 2, 3);
    for (int k = 0; k <= 8; k++) begin
      chk($sformatf("busy_k%0d", k), 32'(busy), (k < 8) ? 1 : 0);
      chk($sformatf("valid_k%0d", k), 32'(out_valid), (k >= 4 && k < 8) ? 1 : 0);
      tick();
    end
    drain();

    // Descending intensity.
    sort_desc = 1'b1;
    push(0, 0); push(0, 3); push(1, 1); push(2, 2);
    send_basic(0, 1, 2, 3);
    drain();

    // Ties: grey image, R/G count tie, identical images sent as index 2 then 1.
    sort_desc = 1'b0;
    push(0, 1); push(0, 2); push(0, 0); push(2, 3);
    send_image(0, 24'h323232);
    repeat (2) send_beat(2, 24'h000900);
    repeat (2) send_beat(2, 24'h090000);
    repeat (2) send_beat(1, 24'h000900);
    repeat (2) send_beat(1, 24'h090000);
    send_image(3, 24'h00001E);
    drain();

    // Random gaps and shuffled image order.
    gaps = 1;
    push_asc();
    send_basic(3, 1, 0, 2);
    gaps = 0;
    drain();

    // Reset mid-SORT, then a full descending frame.
    send_basic(0, 1, 2, 3);
    tick();
    do_reset(1, "rst_sort");
    sort_desc = 1'b1;
    push(0, 0); push(0, 3); push(1, 1); push(2, 2);
    send_basic(2, 0, 3, 1);
    drain();

    // Reset mid-OUT after two records, then a full ascending frame.
    sort_desc = 1'b0;
    push_asc();
    send_basic(0, 1, 2, 3);
    repeat (5) tick();
    chk("mid_out_valid", 32'(out_valid), 1);
    do_reset(1, "rst_out");
    push_asc();
    send_basic(1, 3, 2, 0);
    drain();
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ise_sorter_param.md
# ise_sorter_param

Parametrised image sorting engine, the next-generation ISE core. It streams RGB pixels for `IMAGE_NUM` images and classifies each image by its dominant colour channel. It then sorts all images by colour class and by intensity of that channel, and emits one sorted record per cycle. Compared with the fixed 32×128×128 engine, it adds generic image count, image size and channel width, an `in_valid` qualifier, and a selectable intensity sort direction.

## Interface

- `IMAGE_NUM`, 32: images per frame set; power of two, ≥2.
- `PIXELS`, 16384: pixels per image; power of two, ≥2.
- `CH_W`, 8: bits per colour channel.
- `IDX_W`, $clog2(IMAGE_NUM): image index width (derived).
- `SUM_W`, CH_W+$clog2(PIXELS): intensity accumulator width (derived).

Ports:

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: pixel beat qualifier.
- `image_in_index` in IDX_W: index of the image the beat belongs to.
- `pixel_in` in 3*CH_W: {R,G,B}, R in the MSBs.
- `sort_desc` in 1: 0 = ascending intensity, 1 = descending; sampled on entry to SORT.
- `busy` out 1: registered; 1 = beats are not accepted.
- `out_valid` out 1: registered; one sorted record is present.
- `color_index` out 2: 0 = red, 1 = green, 2 = blue.
- `image_out_index` out IDX_W: image index of the record.

## Operation

- States: LOAD → SORT → OUT → LOAD.
- Reset forces LOAD, zeroes all counters and accumulators, and drives all outputs to 0.
- **Beat acceptance:** a beat is accepted when `in_valid && !busy`. Beats with `in_valid` low are ignored and do not advance any counter.
- **Pixel dominance:**
  - R if R≥G and R≥B.
  - Otherwise G if G≥B.
  - Otherwise B.
  - Ties resolve R over G over B.
- **Per-image accumulation:**
  - Three per-channel pixel counters.
  - Three per-channel value sums, each SUM_W bits, never overflowing.
- **Image completion (PIXELS-th accepted beat):**
  - Image colour = channel with the highest count; ties resolve R over G over B.
  - Key = that channel's sum.
  - The record {colour, key, index} is written to slot `image_in_index` of that final beat.
  - Per-image counters and sums clear.
  - The image counter increments.
- Images arrive contiguously, each index exactly once per frame set, in any index order.
- **Frame-set completion:** when the image counter reaches IMAGE_NUM, the block latches `sort_desc` and enters SORT.
- **SORT:**
  - Odd-even transposition sort over IMAGE_NUM slots, exactly IMAGE_NUM passes, one pass per cycle.
  - Ordering: colour ascending; then key ascending (`sort_desc`=0) or descending (1); then image index ascending.
  - Equal colour and key therefore never reorder by arrival.
- **OUT:**
  - Emits slot 0 … IMAGE_NUM-1, one per cycle, with `out_valid`=1.
  - Then returns to LOAD with the image counter at 0.
  - No backpressure: the consumer must take every record.
- Reset in any state abandons the frame set; a new set starts from the next accepted beat.

## Timing

- Let edge T accept the final beat of the last image.
- `busy` = 1 in the cycles following edges T … T+2·IMAGE_NUM−1.
- `busy` = 0 from edge T+2·IMAGE_NUM.
- SORT passes occur on edges T+1 … T+IMAGE_NUM.
- `out_valid` = 1 for exactly IMAGE_NUM consecutive cycles, after edges T+IMAGE_NUM … T+2·IMAGE_NUM−1.
- `color_index` and `image_out_index` hold 0 when `out_valid`=0.
- Input latency per beat is 1 cycle; the record is available at the edge of the final beat of each image.
- A beat presented in the same cycle `busy` rises is not accepted.

## Test plan

Bench parameters: IMAGE_NUM=4, PIXELS=4, CH_W=8.

- **Reset:** assert `reset` 2 cycles mid-LOAD → `busy`, `out_valid`, `color_index`, `image_out_index` all 0; the next full frame set sorts correctly.
- **Basic sort, ascending:** img0 all (200,10,10); img1 all (10,50,10); img2 all (10,10,90); img3 all (100,10,10); `sort_desc`=0 → outputs (0,3), (0,0), (1,1), (2,2). First `out_valid` exactly 5 cycles after the final beat; `busy` high 8 cycles.
- **Descending:** same stimulus with `sort_desc`=1 → outputs (0,0), (0,3), (1,1), (2,2).
- **Ties:**
  - Image of all (50,50,50) → colour 0, key 200.
  - Image with two (0,9,0) and two (9,0,0) pixels → colour 0, key 18.
  - Two identical images at indices 2 and 1 → index 1 emitted first.
- **Gaps and order:** random `in_valid` deassertion; images sent in index order 3,1,0,2 → outputs identical to the gap-free, in-order run.
- **Reset mid-SORT and mid-OUT:** outputs drop to 0 on the next edge; a subsequent full frame set produces correct order; no stale records are emitted.
